serial_addsub: RTL and testbench

- Parametrised digit-serial adder/subtractor: successor to the single-bit gate-level full adder cell.
- Takes two WIDTH-bit operands and processes BITS_PER_CYCLE bits per clock through a ripple chain of full-adder cells.
- Keeps the carry in a register between digits; returns SUM, COUT and signed overflow with a START/READY/DONE handshake.
- Sits in the datapath lab designs as the area-cheap arithmetic unit for multi-cycle ALUs and accumulators.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 128 ++++++++++++
 tb/tb_serial_addsub.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared state encoding and mode constants for serial_addsub
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// rtl/serial_addsub_fa_cell.sv - one-bit full adder cell used in the digit ripple chain
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor with start/ready/done handshake
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int K     = BITS_PER_CYCLE;
  localparam int N     = WIDTH / K;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Refuse to elaborate when the digit width does not tile the word exactly.
  if (WIDTH < 2 || K < 1 || (WIDTH % K) != 0) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_t             state, state_next;
  logic [WIDTH-1:0]   op_a, op_b, res, res_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [K:0]         c;
  logic [K-1:0]       dsum;
  logic               last;

  assign c[0] = carry;
  assign last = (cnt == CNT_W'(N - 1));

  // Ripple chain across one digit; c[K-1] is the carry into the top cell,
  // which on the final digit is the carry into the word MSB.
  for (genvar i = 0; i < K; i++) begin : g_cell
    fa_cell u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (c[i]),
      .sum  (dsum[i]),
      .cout (c[i+1])
    );
  end

  // Result register shifts right one digit, new digit enters at the top.
  always_comb begin
    res_next = res >> K;
    res_next[WIDTH-1 -: K] = dsum;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    READY      = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      ST_IDLE: begin
        READY = 1'b1;
        if (START) state_next = ST_RUN;
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (last) state_next = ST_FIN;
      end
      ST_FIN: begin
        DONE       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand load, per-digit shift and final result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            op_a  <= A;
            op_b  <= (MODE == MODE_SUB) ? ~B : B;
            carry <= CIN ^ MODE;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          op_a  <= op_a >> K;
          op_b  <= op_b >> K;
          res   <= res_next;
          carry <= c[K];
          cnt   <= cnt + 1'b1;
          if (last) begin
            SUM  <= res_next;
            COUT <= c[K];
            OVF  <= c[K-1] ^ c[K];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
module tb_serial_addsub;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v, mode_v, cin_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [2:0]  ready_v, busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  sum1, sum4;
  logic [15:0] sum16;

  int tests  = 0;
  int failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) d1 (
    .CLK(clk), .RST(rst), .START(start_v[0]), .MODE(mode_v[0]),
    .A(a_v[0][7:0]), .B(b_v[0][7:0]), .CIN(cin_v[0]),
    .READY(ready_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]),
    .SUM(sum1), .COUT(cout_v[0]), .OVF(ovf_v[0])
  );

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) d4 (
    .CLK(clk), .RST(rst), .START(start_v[1]), .MODE(mode_v[1]),
    .A(a_v[1][7:0]), .B(b_v[1][7:0]), .CIN(cin_v[1]),
    .READY(ready_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]),
    .SUM(sum4), .COUT(cout_v[1]), .OVF(ovf_v[1])
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(2)) d16 (
    .CLK(clk), .RST(rst), .START(start_v[2]), .MODE(mode_v[2]),
    .A(a_v[2]), .B(b_v[2]), .CIN(cin_v[2]),
    .READY(ready_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]),
    .SUM(sum16), .COUT(cout_v[2]), .OVF(ovf_v[2])
  );

  function automatic logic [15:0] get_sum(input int sel);
    case (sel)
      0:       get_sum = {8'h00, sum1};
      1:       get_sum = {8'h00, sum4};
      default: get_sum = sum16;
    endcase
  endfunction

  // Issue one operation from IDLE and wait (bounded) for DONE.
  // lat = negedges after the accept edge until DONE seen; -1 on timeout.
  task automatic do_op(input int sel, input logic md, input logic [15:0] aa,
                       input logic [15:0] bb, input logic ci,
                       output int lat, output int bcnt, output logic [15:0] s,
                       output logic co, output logic ov);
    @(negedge clk);
    start_v[sel] = 1'b1; mode_v[sel] = md; cin_v[sel] = ci;
    a_v[sel] = aa; b_v[sel] = bb;
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    a_v[sel] = ~aa; b_v[sel] = ~bb; mode_v[sel] = ~md; cin_v[sel] = ~ci;
    lat = -1; bcnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (busy_v[sel]) bcnt++;
      if (done_v[sel]) begin
        lat = j;
        break;
      end
    end
    s = get_sum(sel); co = cout_v[sel]; ov = ovf_v[sel];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ready_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
        failed++;
        $display("FAIL reset_hs dut%0d: ready=%b busy=%b done=%b, want 1 0 0", k, ready_v[k], busy_v[k], done_v[k]);
      end
      tests++;
      if (get_sum(k) !== 16'h0000 || cout_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
        failed++;
        $display("FAIL reset_res dut%0d: sum=%h cout=%b ovf=%b, want 0 0 0", k, get_sum(k), cout_v[k], ovf_v[k]);
      end
    end
  endtask

  task automatic test_add();
    int lat, bc; logic [15:0] s; logic co, ov;
    do_op(0, 1'b0, 16'h5A, 16'h3C, 1'b0, lat, bc, s, co, ov);
    tests++; if (lat !== 8) begin failed++; $display("FAIL add_lat: got %0d want 8", lat); end
    tests++; if (bc !== 8) begin failed++; $display("FAIL add_busy: got %0d want 8", bc); end
    tests++; if (s !== 16'h96 || co !== 1'b0 || ov !== 1'b1) begin
      failed++; $display("FAIL add_5a3c: sum=%h cout=%b ovf=%b want 96 0 1", s, co, ov); end
    repeat (3) @(negedge clk);
    tests++; if (sum1 !== 8'h96 || ready_v[0] !== 1'b1) begin
      failed++; $display("FAIL add_hold: sum=%h ready=%b want 96 1", sum1, ready_v[0]); end
    do_op(0, 1'b0, 16'hFF, 16'h01, 1'b0, lat, bc, s, co, ov);
    tests++; if (s !== 16'h00 || co !== 1'b1 || ov !== 1'b0) begin
      failed++; $display("FAIL add_ff01: sum=%h cout=%b ovf=%b want 00 1 0", s, co, ov); end
    do_op(0, 1'b0, 16'hFF, 16'h00, 1'b1, lat, bc, s, co, ov);
    tests++; if (s !== 16'h00 || co !== 1'b1 || ov !== 1'b0) begin
      failed++; $display("FAIL add_ff00_cin: sum=%h cout=%b ovf=%b want 00 1 0", s, co, ov); end
  endtask

  task automatic test_sub();
    int lat, bc; logic [15:0] s; logic co, ov;
    do_op(0, 1'b1, 16'h10, 16'h20, 1'b0, lat, bc, s, co, ov);
    tests++; if (s !== 16'hF0 || co !== 1'b0 || ov !== 1'b0) begin
      failed++; $display("FAIL sub_1020: sum=%h cout=%b ovf=%b want f0 0 0", s, co, ov); end
    do_op(0, 1'b1, 16'h80, 16'h01, 1'b0, lat, bc, s, co, ov);
    tests++; if (s !== 16'h7F || co !== 1'b1 || ov !== 1'b1) begin
      failed++; $display("FAIL sub_8001: sum=%h cout=%b ovf=%b want 7f 1 1", s, co, ov); end
    do_op(0, 1'b1, 16'h05, 16'h02, 1'b1, lat, bc, s, co, ov);
    tests++; if (s !== 16'h02 || co !== 1'b1 || ov !== 1'b0) begin
      failed++; $display("FAIL sub_borrowin: sum=%h cout=%b ovf=%b want 02 1 0", s, co, ov); end
  endtask

  task automatic test_wide_digits();
    int lat, bc; logic [15:0] s; logic co, ov;
    do_op(1, 1'b0, 16'h5A, 16'h3C, 1'b0, lat, bc, s, co, ov);
    tests++; if (lat !== 2) begin failed++; $display("FAIL k4_lat: got %0d want 2", lat); end
    tests++; if (s !== 16'h96 || co !== 1'b0 || ov !== 1'b1) begin
      failed++; $display("FAIL k4_sum: sum=%h cout=%b ovf=%b want 96 0 1", s, co, ov); end
    do_op(2, 1'b0, 16'h7FFF, 16'h0001, 1'b0, lat, bc, s, co, ov);
    tests++; if (lat !== 8) begin failed++; $display("FAIL w16_lat: got %0d want 8", lat); end
    tests++; if (s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
      failed++; $display("FAIL w16_sum: sum=%h cout=%b ovf=%b want 8000 0 1", s, co, ov); end
  endtask

  task automatic test_ignored_start();
    int ndone, done_j, ready_j;
    @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 1'b0; cin_v[0] = 1'b0; a_v[0] = 16'h5A; b_v[0] = 16'h3C;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    ndone = 0; done_j = -1; ready_j = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done_v[0]) begin ndone++; done_j = j; end
      if (ready_v[0] && done_j >= 0 && ready_j < 0) ready_j = j;
      if (j == 2) begin start_v[0] = 1'b1; a_v[0] = 16'h01; b_v[0] = 16'h01; end
      if (j == 3) start_v[0] = 1'b0;
    end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL ign_ndone: got %0d want 1", ndone); end
    tests++; if (sum1 !== 8'h96) begin failed++; $display("FAIL ign_sum: got %h want 96", sum1); end
    tests++; if (done_j !== 8 || ready_j !== 9) begin
      failed++; $display("FAIL ign_ready: done_at=%0d ready_at=%0d want 8 9", done_j, ready_j); end
  endtask

  task automatic test_back_to_back();
    int d0, d1c;
    d0 = -1; d1c = -1;
    @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 1'b0; cin_v[0] = 1'b0; a_v[0] = 16'h03; b_v[0] = 16'h04;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (d0 < 0) d0 = j;
        else if (d1c < 0) d1c = j;
      end
    end
    start_v[0] = 1'b0;
    tests++; if (d0 < 0 || d1c - d0 !== 10) begin
      failed++; $display("FAIL b2b_period: first=%0d second=%0d want gap 10", d0, d1c); end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ready_v[0]) break;
    end
  endtask

  task automatic test_reset_midop();
    int ndone, lat, bc; logic [15:0] s; logic co, ov;
    @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 1'b0; cin_v[0] = 1'b0; a_v[0] = 16'h5A; b_v[0] = 16'h3C;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    for (int j = 0; j < 3; j++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || sum1 !== 8'h00) begin
      failed++; $display("FAIL midrst_state: ready=%b busy=%b done=%b sum=%h want 1 0 0 00",
                         ready_v[0], busy_v[0], done_v[0], sum1); end
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    tests++; if (ndone !== 0) begin failed++; $display("FAIL midrst_nodone: got %0d want 0", ndone); end
    do_op(0, 1'b0, 16'h03, 16'h04, 1'b0, lat, bc, s, co, ov);
    tests++; if (s !== 16'h07 || co !== 1'b0 || ov !== 1'b0 || lat !== 8) begin
      failed++; $display("FAIL midrst_fresh: sum=%h cout=%b ovf=%b lat=%0d want 07 0 0 8", s, co, ov, lat); end
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0; mode_v = '0; cin_v = '0;
    for (int k = 0; k < 3; k++) begin a_v[k] = '0; b_v[k] = '0; end
    test_reset();
    test_add();
    test_sub();
    test_wide_digits();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
